// File: rtl/sdram_resp_pkg.sv
// sdram_responder shared types: FSM state encoding and LFSR constants.
// Random-stall feature is enabled by defining SDRAM_RESP_RANDSTALL_EN.
package sdram_resp_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REFRESH = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// On-chip word store for sdram_responder: per-byte write enable,
// registered read output (first stage of the read pipeline).
module sdram_resp_mem
    import sdram_resp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [1:0]    be_n_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [2**AW];
    logic [15:0] rdata_q;

    // Byte-masked write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (!be_n_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
            if (!be_n_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// Avalon-style SDRAM controller stand-in with init/refresh stalls and
// fixed read latency. Define SDRAM_RESP_RANDSTALL_EN for LFSR stalls.
module sdram_responder
    import sdram_resp_pkg::*;
#(
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 16,
    parameter int MEM_AW         = 12,
    parameter int READ_LAT       = 3,
    parameter int MAX_OUT        = 2,
    parameter int INIT_CYCLES    = 16,
    parameter int REFRESH_PERIOD = 390,
    parameter int REFRESH_LEN    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] az_addr,
    input  logic [DATA_W-1:0] az_data,
    input  logic [1:0]        az_be_n,
    input  logic              az_rd_n,
    input  logic              az_wr_n,
    output logic [DATA_W-1:0] za_data,
    output logic              za_valid,
    output logic              za_waitrequest
);

    localparam int CNT_W = 16;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] INIT_RLD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_RLD  = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [CNT_W-1:0] REF_RLD  = CNT_W'(REFRESH_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;

    logic [READ_LAT:1]             vld_q;
    logic [READ_LAT:2][DATA_W-1:0] dat_q;

    logic              stall;
    logic              req, acc, wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_data;
    logic              unused_addr;

    assign unused_addr = ^az_addr[ADDR_W-1:MEM_AW];

`ifdef SDRAM_RESP_RANDSTALL_EN
    logic [15:0] lfsr_q;

    // Free-running LFSR; low two bits zero marks a stall cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign za_waitrequest = reset
                          | (state_q != ST_RUN)
                          | (out_q == OUT_W'(MAX_OUT))
                          | stall;

    assign req    = ~az_rd_n | ~az_wr_n;
    assign acc    = req & ~za_waitrequest;
    assign wr_acc = acc & ~az_wr_n;
    assign rd_acc = acc & az_wr_n & ~az_rd_n;

    // Phase sequencing: one down-counter reloaded on each transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = RUN_RLD;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_REFRESH;
                    cnt_d   = REF_RLD;
                end
            end
            ST_REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = RUN_RLD;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = INIT_RLD;
            end
        endcase
    end

    // Reads in flight: up on accept, down when data leaves
    always_comb begin
        out_d = out_q;
        unique case ({rd_acc, za_valid})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    // State, counter and outstanding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= INIT_RLD;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    sdram_resp_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .be_n_i  (az_be_n),
        .re_i    (rd_acc),
        .addr_i  (az_addr[MEM_AW-1:0]),
        .wdata_i (az_data),
        .rdata_o (rd_data)
    );

    // Valid-tagged read pipeline; data stages load only behind a valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[1] <= rd_acc;
            for (int k = 2; k <= READ_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            if (vld_q[1]) dat_q[2] <= rd_data;
            for (int k = 3; k <= READ_LAT; k++) begin
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign za_valid = vld_q[READ_LAT];
    assign za_data  = dat_q[READ_LAT];

endmodule
